// File: rtl/cr_sa_ctrl_if.sv
// Command and dump handshake bundle between a host and the sa counter controller.
interface cr_sa_ctrl_if #(
    parameter int IDX_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [IDX_W-1:0] cmd_idx;
    logic [9:0]       cmd_sel;

    logic             dump_valid;
    logic             dump_ready;
    logic [IDX_W-1:0] dump_idx;
    logic [49:0]      dump_data;
    logic             dump_last;

    // Host side: issues commands and consumes dump beats.
    modport master (
        output cmd_valid, cmd_op, cmd_idx, cmd_sel, dump_ready,
        input  cmd_ready, dump_valid, dump_idx, dump_data, dump_last
    );

    // Controller side: accepts commands and produces dump beats.
    modport slave (
        input  cmd_valid, cmd_op, cmd_idx, cmd_sel, dump_ready,
        output cmd_ready, dump_valid, dump_idx, dump_data, dump_last
    );
endinterface

// File: rtl/cr_sa_ctrl.sv
// Controller for a bank of sa counters: programs per-counter event selects,
// issues clear/snapshot strobes and streams snapshot values out as dump beats.
module cr_sa_ctrl #(
    parameter int N_CNT = 6,
    parameter int IDX_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    cr_sa_ctrl_if.slave        bus,
    output logic [N_CNT*10-1:0] sa_event_sel,
    output logic [N_CNT-1:0]   sa_clear,
    output logic [N_CNT-1:0]   sa_snap,
    input  logic [N_CNT*50-1:0] sa_snapshot,
    output logic               cmd_err,
    output logic               busy
);

    localparam logic [1:0] OP_SET_SEL   = 2'd0;
    localparam logic [1:0] OP_CLEAR     = 2'd1;
    localparam logic [1:0] OP_SNAP      = 2'd2;
    localparam logic [1:0] OP_SNAP_DUMP = 2'd3;

    localparam logic [IDX_W:0]   CNT_LIM  = (IDX_W+1)'(N_CNT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CNT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        SETTLE = 2'd2,
        DUMP   = 2'd3
    } state_t;

    state_t           state;
    logic             dump_pending;
    logic             dump_valid;
    logic             dump_last;
    logic [IDX_W-1:0] dump_idx;
    logic [49:0]      dump_data;
    logic             idx_in_range;

    assign idx_in_range   = ({1'b0, bus.cmd_idx} < CNT_LIM);
    assign bus.cmd_ready  = (state == IDLE);
    assign bus.dump_valid = dump_valid;
    assign bus.dump_last  = dump_last;
    assign bus.dump_idx   = dump_idx;
    assign bus.dump_data  = dump_data;

    // Select the snapshot slice of the counter currently being dumped.
    always_comb begin
        dump_data = '0;
        for (int k = 0; k < N_CNT; k++) begin
            if (dump_idx == IDX_W'(k)) begin
                dump_data = sa_snapshot[k*50 +: 50];
            end
        end
    end

    // Command FSM; every output except cmd_ready and dump_data is registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            dump_pending <= 1'b0;
            sa_event_sel <= '0;
            sa_clear     <= '0;
            sa_snap      <= '0;
            dump_valid   <= 1'b0;
            dump_last    <= 1'b0;
            dump_idx     <= '0;
            cmd_err      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            sa_clear <= '0;
            sa_snap  <= '0;
            cmd_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        case (bus.cmd_op)
                            OP_SET_SEL: begin
                                if (idx_in_range) begin
                                    for (int k = 0; k < N_CNT; k++) begin
                                        if (bus.cmd_idx == IDX_W'(k)) begin
                                            sa_event_sel[k*10 +: 10] <= bus.cmd_sel;
                                        end
                                    end
                                end else begin
                                    cmd_err <= 1'b1;
                                end
                            end
                            OP_CLEAR: begin
                                sa_clear     <= '1;
                                dump_pending <= 1'b0;
                                state        <= STROBE;
                                busy         <= 1'b1;
                            end
                            OP_SNAP: begin
                                sa_snap      <= '1;
                                dump_pending <= 1'b0;
                                state        <= STROBE;
                                busy         <= 1'b1;
                            end
                            OP_SNAP_DUMP: begin
                                sa_snap      <= '1;
                                dump_pending <= 1'b1;
                                state        <= STROBE;
                                busy         <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                STROBE: begin
                    if (dump_pending) begin
                        state <= SETTLE;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                SETTLE: begin
                    dump_pending <= 1'b0;
                    dump_valid   <= 1'b1;
                    dump_idx     <= '0;
                    dump_last    <= (LAST_IDX == '0);
                    state        <= DUMP;
                end
                DUMP: begin
                    if (dump_valid && bus.dump_ready) begin
                        if (dump_last) begin
                            dump_valid <= 1'b0;
                            dump_last  <= 1'b0;
                            dump_idx   <= '0;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            dump_idx  <= dump_idx + 1'b1;
                            dump_last <= ((dump_idx + 1'b1) == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cr_sa_ctrl.sv
// Directed bench for cr_sa_ctrl with N_CNT=6: event select writes, index
// errors, strobes, snapshot dumps with back-pressure and reset mid-dump.
module tb_cr_sa_ctrl;

    localparam int N_CNT = 6;
    localparam int IDX_W = 3;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N_CNT*10-1:0]   sa_event_sel;
    logic [N_CNT-1:0]      sa_clear;
    logic [N_CNT-1:0]      sa_snap;
    logic [N_CNT*50-1:0]   sa_snapshot;
    logic                  cmd_err;
    logic                  busy;

    int checks = 0;
    int errors = 0;
    logic [N_CNT*10-1:0] exp_sel;
    logic [49:0]         snap_base;

    cr_sa_ctrl_if #(.IDX_W(IDX_W)) bus ();

    cr_sa_ctrl #(.N_CNT(N_CNT), .IDX_W(IDX_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .sa_event_sel (sa_event_sel),
        .sa_clear     (sa_clear),
        .sa_snap      (sa_snap),
        .sa_snapshot  (sa_snapshot),
        .cmd_err      (cmd_err),
        .busy         (busy)
    );

    // 100 MHz free-running clock.
    always #5 clk = ~clk;

    // Compare one observed value with its expected value and tally the outcome.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one command for one accepting edge, then withdraw it.
    task automatic applyStimulus(input logic [1:0] op, input logic [IDX_W-1:0] idx, input logic [9:0] sel);
        checkOutput("cmd_ready_before_cmd", 64'(bus.cmd_ready), 64'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_idx   = idx;
        bus.cmd_sel   = sel;
        step();
        bus.cmd_valid = 1'b0;
    endtask

    // Load every snapshot slice with base + k.
    task automatic loadSnapshots(input logic [49:0] base);
        for (int k = 0; k < N_CNT; k++) begin
            sa_snapshot[k*50 +: 50] = base + 50'(k);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = 2'd0;
        bus.cmd_idx    = '0;
        bus.cmd_sel    = '0;
        bus.dump_ready = 1'b1;
        sa_snapshot    = '0;
        exp_sel        = '0;

        // Reset state.
        step();
        step();
        checkOutput("rst_event_sel", 64'(sa_event_sel), 64'd0);
        checkOutput("rst_clear", 64'(sa_clear), 64'd0);
        checkOutput("rst_snap", 64'(sa_snap), 64'd0);
        checkOutput("rst_dump_valid", 64'(bus.dump_valid), 64'd0);
        checkOutput("rst_dump_last", 64'(bus.dump_last), 64'd0);
        checkOutput("rst_dump_idx", 64'(bus.dump_idx), 64'd0);
        checkOutput("rst_cmd_err", 64'(cmd_err), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        checkOutput("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);

        // SET_SEL idx 2 = 0x2C5.
        applyStimulus(2'd0, 3'd2, 10'h2C5);
        exp_sel = 60'h2C5 << 20;
        checkOutput("setsel2_vec", 64'(sa_event_sel), 64'(exp_sel));
        checkOutput("setsel2_err", 64'(cmd_err), 64'd0);
        checkOutput("setsel2_busy", 64'(busy), 64'd0);

        // SET_SEL on the lowest and highest legal indices.
        applyStimulus(2'd0, 3'd0, 10'h3FF);
        exp_sel[9:0] = 10'h3FF;
        checkOutput("setsel0_vec", 64'(sa_event_sel), 64'(exp_sel));
        applyStimulus(2'd0, 3'd5, 10'h155);
        exp_sel[59:50] = 10'h155;
        checkOutput("setsel5_vec", 64'(sa_event_sel), 64'(exp_sel));
        checkOutput("setsel5_err", 64'(cmd_err), 64'd0);

        // Out-of-range indices 7 and 6 flag an error and write nothing.
        applyStimulus(2'd0, 3'd7, 10'h0AA);
        checkOutput("setsel7_vec", 64'(sa_event_sel), 64'(exp_sel));
        checkOutput("setsel7_err", 64'(cmd_err), 64'd1);
        checkOutput("setsel7_ready", 64'(bus.cmd_ready), 64'd1);
        step();
        checkOutput("setsel7_err_drop", 64'(cmd_err), 64'd0);
        applyStimulus(2'd0, 3'd6, 10'h111);
        checkOutput("setsel6_vec", 64'(sa_event_sel), 64'(exp_sel));
        checkOutput("setsel6_err", 64'(cmd_err), 64'd1);
        step();
        checkOutput("setsel6_err_drop", 64'(cmd_err), 64'd0);

        // CLEAR: one strobe cycle, then idle.
        applyStimulus(2'd1, 3'd0, 10'h0);
        checkOutput("clear_strobe", 64'(sa_clear), 64'h3F);
        checkOutput("clear_no_snap", 64'(sa_snap), 64'd0);
        checkOutput("clear_ready_low", 64'(bus.cmd_ready), 64'd0);
        checkOutput("clear_busy", 64'(busy), 64'd1);
        checkOutput("clear_err", 64'(cmd_err), 64'd0);
        step();
        checkOutput("clear_strobe_end", 64'(sa_clear), 64'd0);
        checkOutput("clear_ready_back", 64'(bus.cmd_ready), 64'd1);
        checkOutput("clear_busy_end", 64'(busy), 64'd0);

        // SNAP: one strobe cycle, then idle.
        applyStimulus(2'd2, 3'd0, 10'h0);
        checkOutput("snap_strobe", 64'(sa_snap), 64'h3F);
        checkOutput("snap_no_clear", 64'(sa_clear), 64'd0);
        step();
        checkOutput("snap_strobe_end", 64'(sa_snap), 64'd0);
        checkOutput("snap_ready_back", 64'(bus.cmd_ready), 64'd1);

        // CLEAR held valid: accepted every second cycle.
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd1;
        for (int c = 0; c < 4; c++) begin
            step();
            checkOutput($sformatf("b2b_clear_%0d", c), 64'(sa_clear), (c % 2 == 0) ? 64'h3F : 64'd0);
        end
        bus.cmd_valid = 1'b0;
        step();
        checkOutput("b2b_settled", 64'(sa_clear), 64'd0);
        checkOutput("sel_kept", 64'(sa_event_sel), 64'(exp_sel));

        // SNAP_DUMP with dump_ready always high.
        snap_base = 50'h1000;
        loadSnapshots(snap_base);
        bus.dump_ready = 1'b1;
        applyStimulus(2'd3, 3'd0, 10'h0);
        checkOutput("sd_snap_t1", 64'(sa_snap), 64'h3F);
        checkOutput("sd_valid_t1", 64'(bus.dump_valid), 64'd0);
        checkOutput("sd_busy_t1", 64'(busy), 64'd1);
        step();
        checkOutput("sd_snap_t2", 64'(sa_snap), 64'd0);
        checkOutput("sd_valid_t2", 64'(bus.dump_valid), 64'd0);
        checkOutput("sd_busy_t2", 64'(busy), 64'd1);
        checkOutput("sd_ready_t2", 64'(bus.cmd_ready), 64'd0);
        for (int k = 0; k < N_CNT; k++) begin
            step();
            checkOutput($sformatf("sd_valid_%0d", k), 64'(bus.dump_valid), 64'd1);
            checkOutput($sformatf("sd_idx_%0d", k), 64'(bus.dump_idx), 64'(k));
            checkOutput($sformatf("sd_data_%0d", k), 64'(bus.dump_data), 64'h1000 + 64'(k));
            checkOutput($sformatf("sd_last_%0d", k), 64'(bus.dump_last), (k == N_CNT-1) ? 64'd1 : 64'd0);
        end
        step();
        checkOutput("sd_valid_end", 64'(bus.dump_valid), 64'd0);
        checkOutput("sd_busy_end", 64'(busy), 64'd0);
        checkOutput("sd_idx_end", 64'(bus.dump_idx), 64'd0);
        checkOutput("sd_ready_end", 64'(bus.cmd_ready), 64'd1);

        // SNAP_DUMP with three stalled cycles on idx 2.
        snap_base = 50'h2_A000_0000_0000;
        loadSnapshots(snap_base);
        applyStimulus(2'd3, 3'd0, 10'h0);
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            checkOutput($sformatf("st_idx_%0d", k), 64'(bus.dump_idx), 64'(k));
        end
        bus.dump_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            checkOutput($sformatf("st_hold_idx_%0d", c), 64'(bus.dump_idx), 64'd2);
            checkOutput($sformatf("st_hold_data_%0d", c), 64'(bus.dump_data), 64'h2_A000_0000_0002);
            checkOutput($sformatf("st_hold_valid_%0d", c), 64'(bus.dump_valid), 64'd1);
        end
        bus.dump_ready = 1'b1;
        for (int k = 3; k < N_CNT; k++) begin
            step();
            checkOutput($sformatf("st_idx_%0d", k), 64'(bus.dump_idx), 64'(k));
            checkOutput($sformatf("st_data_%0d", k), 64'(bus.dump_data), 64'h2_A000_0000_0000 + 64'(k));
            checkOutput($sformatf("st_last_%0d", k), 64'(bus.dump_last), (k == N_CNT-1) ? 64'd1 : 64'd0);
        end
        step();
        checkOutput("st_valid_end", 64'(bus.dump_valid), 64'd0);

        // Reset asserted during the idx 3 beat aborts the dump.
        applyStimulus(2'd3, 3'd0, 10'h0);
        step();
        for (int k = 0; k < 4; k++) begin
            step();
        end
        checkOutput("rd_idx3", 64'(bus.dump_idx), 64'd3);
        rst_n = 1'b0;
        step();
        checkOutput("rd_valid", 64'(bus.dump_valid), 64'd0);
        checkOutput("rd_busy", 64'(busy), 64'd0);
        checkOutput("rd_event_sel", 64'(sa_event_sel), 64'd0);
        checkOutput("rd_idx", 64'(bus.dump_idx), 64'd0);
        rst_n = 1'b1;
        checkOutput("rd_ready", 64'(bus.cmd_ready), 64'd1);
        for (int c = 0; c < 4; c++) begin
            step();
            checkOutput($sformatf("rd_no_snap_%0d", c), 64'(sa_snap), 64'd0);
            checkOutput($sformatf("rd_no_beat_%0d", c), 64'(bus.dump_valid), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cr_sa_ctrl.md
CR_SA_CTRL -- requirements
Module: cr_sa_ctrl

Interface
REQ-001 Parameter N_CNT, default 6: number of sa counter instances controlled; legal range 2..8.
REQ-002 Parameter IDX_W, default 3: width of counter index fields; SHALL satisfy 2**IDX_W >= N_CNT.
REQ-003 clk  input  1  sole clock; all logic on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  command accept; transfer occurs when cmd_valid and cmd_ready are both high at a rising edge.
REQ-007 cmd_op  input  2  opcode: 0 SET_SEL, 1 CLEAR, 2 SNAP, 3 SNAP_DUMP.
REQ-008 cmd_idx  input  IDX_W  target counter for SET_SEL; ignored for other ops.
REQ-009 cmd_sel  input  10  event select value for SET_SEL.
REQ-010 sa_event_sel  output  N_CNT*10  per-counter event select; counter k uses bits [k*10+9:k*10].
REQ-011 sa_clear  output  N_CNT  per-counter clear strobe.
REQ-012 sa_snap  output  N_CNT  per-counter snapshot strobe.
REQ-013 sa_snapshot  input  N_CNT*50  per-counter snapshot value; counter k uses bits [k*50+49:k*50].
REQ-014 dump_valid  output  1  dump beat valid.
REQ-015 dump_ready  input  1  dump beat accept.
REQ-016 dump_idx  output  IDX_W  counter index of the current beat.
REQ-017 dump_data  output  50  snapshot value of counter dump_idx.
REQ-018 dump_last  output  1  high on the beat with dump_idx == N_CNT-1.
REQ-019 cmd_err  output  1  one-cycle pulse flagging an illegal index.
REQ-020 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-021 FSM states SHALL be IDLE, STROBE, SETTLE, DUMP.
REQ-022 cmd_ready SHALL equal (state == IDLE); no command is accepted in any other state.
REQ-023 SET_SEL accepted with cmd_idx < N_CNT: the selected 10-bit slice SHALL take cmd_sel at that edge; other slices unchanged; FSM stays IDLE.
REQ-024 SET_SEL with cmd_idx >= N_CNT: command SHALL be consumed, no slice written, cmd_err high for the following cycle only.
REQ-025 CLEAR accepted at edge T: sa_clear SHALL be all-ones for exactly the cycle after T (state STROBE), then return to IDLE.
REQ-026 SNAP accepted at edge T: sa_snap SHALL be all-ones for exactly the cycle after T (state STROBE), then return to IDLE.
REQ-027 SNAP_DUMP accepted at edge T: sa_snap all-ones in cycle T+1 (STROBE), then SETTLE for cycle T+2, then DUMP from cycle T+3.
REQ-028 In DUMP, dump_valid SHALL be high, dump_idx SHALL start at 0, and dump_data SHALL equal the sa_snapshot slice selected by dump_idx (combinational mux).
REQ-029 dump_idx SHALL advance by 1 only on edges where dump_valid and dump_ready are both high; while dump_ready is low, dump_idx and dump_data hold.
REQ-030 Accepted beat with dump_last high: FSM SHALL return to IDLE and dump_idx SHALL reset to 0; dump_valid is low the next cycle.
REQ-031 sa_clear and sa_snap SHALL be registered outputs, never high together, and low outside STROBE.
REQ-032 Back-to-back commands: a new command SHALL be accepted no earlier than the first IDLE cycle after the previous one completes; CLEAR/SNAP therefore take a minimum of 2 cycles per command.
REQ-033 cmd_err SHALL be low for all ops other than out-of-range SET_SEL.
REQ-034 busy SHALL be registered from the state and high in STROBE, SETTLE and DUMP.

Reset
REQ-035 rst_n low at a rising edge SHALL force: state IDLE; sa_event_sel all zero; sa_clear, sa_snap zero; dump_valid, dump_last, cmd_err, busy zero; dump_idx zero.
REQ-036 Reset asserted mid-dump or mid-strobe SHALL abort the operation with no further strobes or beats; cmd_ready is high in the first cycle after rst_n returns high.

Verification
REQ-037 SET_SEL idx=2 sel=0x2C5 -> sa_event_sel[29:20]=0x2C5 next cycle, other slices 0, cmd_err 0.
REQ-038 SET_SEL idx=7 (N_CNT=6) -> no slice changes, cmd_err pulses 1 cycle, cmd_ready stays high.
REQ-039 CLEAR accepted at edge T -> sa_clear=6'h3F in cycle T+1 only, cmd_ready low in T+1 and high in T+2.
REQ-040 SNAP_DUMP with snapshot k = 0x1000+k, dump_ready always high -> 6 beats, idx 0..5, data 0x1000..0x1005, dump_last on idx 5, first beat in cycle T+3.
REQ-041 SNAP_DUMP with dump_ready low for 3 cycles on idx 2 -> idx 2 and its data hold for 3 cycles, no beat dropped or duplicated.
REQ-042 rst_n low during the idx 3 beat -> dump_valid 0 and busy 0 next cycle, sa_event_sel zeroed, no sa_snap pulse after reset.
